trigger_conditioner: RTL and testbench
======================================

# trigger_conditioner

Input-side conditioning stage for the glitcher: takes the raw asynchronous target trigger pin, synchronises and glitch-filters it, selects the qualifying edge, and applies arm/holdoff/Nth-edge gating. It emits the single-cycle `trigger` strobe consumed by `glitch_control`. It is instantiated between `ui_in[6]` and `glitch_control.trigger_i`. Configuration comes from the UART command path.

## Interface
Parameters:
- `FILTER_W`, 4, width of the glitch-filter length field
- `COUNT_W`, 8, width of the edge counter and the Nth-edge setting
- `HOLDOFF_W`, 16, width of the post-arm holdoff counter

Ports:
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  reset, synchronous, active-low
- `trigger_i`  in  1  raw asynchronous trigger pin
- `arm_i`  in  1  one-cycle pulse; (re)arms the block and latches the config
- `disarm_i`  in  1  one-cycle pulse; returns the block to IDLE
- `edge_sel_i`  in  2  00 rising, 01 falling, 10 both, 11 high level
- `filter_len_i`  in  FILTER_W  number of extra stable cycles required before a level change is accepted
- `edge_count_i`  in  COUNT_W  fire on the Nth qualified edge; 0 is treated as 1
- `holdoff_i`  in  HOLDOFF_W  cycles after arm during which edges are ignored
- `trigger_o`  out  1  one-cycle strobe to `glitch_control`
- `armed_o`  out  1  high in HOLDOFF and ARMED
- `fired_o`  out  1  sticky; high in FIRED
- `edges_seen_o`  out  COUNT_W  qualified edges counted since the last arm

## Operation
- Synchroniser: two flops, `s1` then `s2`, both reset to 0.
- Glitch filter:
  - Filtered level `filt` resets to 0. Counter `fcnt` resets to 0.
  - Each cycle with `s2 != filt`: if `fcnt == filter_len_i`, then `filt <= s2` and `fcnt <= 0`; otherwise `fcnt` increments.
  - Any cycle with `s2 == filt` clears `fcnt`.
  - `filter_len_i = 0` means pass-through with one cycle of delay.
- Edge detect: compare `filt` against its one-cycle-delayed copy `filt_d`.
  - Rising: `filt & ~filt_d`. Falling: the inverse. Both: XOR of the two.
  - Because `filt` resets to 0, a pin held high through reset produces one rising edge after reset. The holdoff exists to mask this.
- Configuration (`edge_sel`, `edge_count`, `holdoff`) is latched on `arm_i`. Live inputs are ignored at all other times.
- State machine (reset to IDLE):
  - IDLE: ignore edges. `arm_i` → HOLDOFF.
  - HOLDOFF: load `hcnt = holdoff`. Decrement every cycle. Edges are ignored. When `hcnt == 0`, go to ARMED; holdoff 0 means one cycle in HOLDOFF.
  - ARMED: each qualified edge increments `edges_seen`. On the edge that makes `edges_seen == N`: pulse `trigger_o` the next cycle and go to FIRED.
  - ARMED, level mode (11): the first ARMED cycle with `filt == 1` fires. `edge_count` is ignored.
  - FIRED: `trigger_o` low, `fired_o` high, `edges_seen` holds at N. Stay until `arm_i` or `disarm_i`.
- `arm_i` in any state: clear `edges_seen`, clear `fired_o`, reload config, enter HOLDOFF. A qualifying edge in the same cycle as `arm_i` is not counted.
- `disarm_i` in any state: go to IDLE, clear `fired_o` and `edges_seen`.
- `disarm_i` and `arm_i` in the same cycle: `disarm_i` wins.
- `edges_seen` cannot wrap: firing occurs at N ≤ 2^COUNT_W−1.

## Timing
- Reset: `trigger_o`, `armed_o`, `fired_o`, `edges_seen_o` are all 0. State IDLE; `s1`, `s2`, `filt`, `filt_d`, `fcnt`, `hcnt` are all 0.
- `rst_n` low mid-operation aborts everything on the next edge with no `trigger_o` pulse.
- Latency: first clock edge that samples `trigger_i` at its new level = edge 0. With block ARMED, N = 1, edge-mode match, `trigger_o` is high during the cycle after edge 3 + F, where F = `filter_len`.
- `trigger_o` is registered, exactly one cycle wide, and at most once per arm.
- `armed_o` rises the cycle after `arm_i` is sampled. It falls in the same cycle `trigger_o` rises.
- `edges_seen_o` is registered and updates one cycle after the qualifying edge is detected.
- Minimum accepted pulse width at `trigger_i`: F + 1 cycles. Shorter pulses are dropped entirely.

## Test plan
- Rising mode, F=0, N=1, holdoff=0; arm, wait 5 cycles, raise `trigger_i` → `trigger_o` high exactly 3 cycles after the sampling edge, one cycle wide; `fired_o` = 1, `armed_o` = 0.
- F=3; apply a 3-cycle high pulse, then a 4-cycle high pulse → the first produces nothing; the second fires at latency 6.
- Both-edges mode, N=5; toggle `trigger_i` every 10 cycles → `edges_seen_o` steps 1..5, `trigger_o` pulses on the 5th edge only, and later edges are ignored.
- Holdoff=20, edge arriving 10 cycles after arm → not counted; edge at 30 cycles → fires. Also hold the pin high through reset with holdoff=10 → no fire.
- Level mode with the pin already high when arming, holdoff=0 → fires within 2 cycles of entering ARMED.
- `arm_i` and `disarm_i` in the same cycle → IDLE. `rst_n` low while `edges_seen` = 2 of 4 → all outputs 0 next cycle, and no `trigger_o` thereafter.

Source files
------------

// File: rtl/trigger_conditioner.sv
// rtl/trigger_conditioner.sv - trigger pin synchroniser, glitch filter, edge select and arm/holdoff/Nth-edge gating
// Produces a one-cycle registered trigger strobe for the glitch controller.
module trigger_conditioner #(
  parameter int FILTER_W  = 4,
  parameter int COUNT_W   = 8,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trigger_i,
  input  logic                 arm_i,
  input  logic                 disarm_i,
  input  logic [1:0]           edge_sel_i,
  input  logic [FILTER_W-1:0]  filter_len_i,
  input  logic [COUNT_W-1:0]   edge_count_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  output logic                 trigger_o,
  output logic                 armed_o,
  output logic                 fired_o,
  output logic [COUNT_W-1:0]   edges_seen_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_ARMED   = 2'd2,
    ST_FIRED   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_s1;
  logic                 r_s2;
  logic                 r_filt;
  logic                 r_filt_d;
  logic [FILTER_W-1:0]  r_fcnt;
  logic [1:0]           r_edge_sel;
  logic [COUNT_W-1:0]   r_edge_count;
  logic [COUNT_W-1:0]   r_edges;
  logic [HOLDOFF_W-1:0] r_hcnt;
  logic                 r_trig;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_qual;
  logic                 w_level_mode;
  logic                 w_fire;
  logic [COUNT_W-1:0]   w_target;
  logic [COUNT_W-1:0]   w_edges_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= trigger_i;
      r_s2 <= r_s1;
    end
  end

  // A level change is accepted only after filter_len_i extra cycles of disagreement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_s2 != r_filt) begin
        if (r_fcnt == filter_len_i) begin
          r_filt <= r_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FILTER_W'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign w_rise = r_filt & ~r_filt_d;
  assign w_fall = ~r_filt & r_filt_d;

  always_comb begin
    w_qual = 1'b0;
    case (r_edge_sel)
      2'b00:   w_qual = w_rise;
      2'b01:   w_qual = w_fall;
      2'b10:   w_qual = w_rise | w_fall;
      default: w_qual = 1'b0;
    endcase
  end

  assign w_level_mode = (r_edge_sel == 2'b11);
  assign w_target     = (r_edge_count == '0) ? COUNT_W'(1) : r_edge_count;
  assign w_edges_inc  = r_edges + COUNT_W'(1);
  assign w_fire       = w_level_mode ? r_filt : (w_qual && (w_edges_inc == w_target));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_edge_sel   <= 2'b00;
      r_edge_count <= '0;
    end else if (arm_i && !disarm_i) begin
      r_edge_sel   <= edge_sel_i;
      r_edge_count <= edge_count_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (disarm_i) begin
      w_next = ST_IDLE;
    end else if (arm_i) begin
      w_next = ST_HOLDOFF;
    end else begin
      case (r_state)
        ST_HOLDOFF: if (r_hcnt == '0) w_next = ST_ARMED;
        ST_ARMED:   if (w_fire) w_next = ST_FIRED;
        default:    w_next = r_state;
      endcase
    end
  end

  always_comb begin
    armed_o = 1'b0;
    fired_o = 1'b0;
    case (r_state)
      ST_HOLDOFF: armed_o = 1'b1;
      ST_ARMED:   armed_o = 1'b1;
      ST_FIRED:   fired_o = 1'b1;
      default:    armed_o = 1'b0;
    endcase
  end

  // Edges coincident with arm/disarm are dropped: those branches take priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hcnt  <= '0;
      r_edges <= '0;
      r_trig  <= 1'b0;
    end else begin
      r_trig <= (r_state == ST_ARMED) && (w_next == ST_FIRED);
      if (disarm_i) begin
        r_hcnt  <= '0;
        r_edges <= '0;
      end else if (arm_i) begin
        r_hcnt  <= holdoff_i;
        r_edges <= '0;
      end else begin
        if ((r_state == ST_HOLDOFF) && (r_hcnt != '0)) begin
          r_hcnt <= r_hcnt - HOLDOFF_W'(1);
        end
        if ((r_state == ST_ARMED) && w_qual) begin
          r_edges <= w_edges_inc;
        end
      end
    end
  end

  assign trigger_o    = r_trig;
  assign edges_seen_o = r_edges;

endmodule

// File: tb/tb_trigger_conditioner.sv
// tb/tb_trigger_conditioner.sv - directed and random checks of trigger_conditioner against a behavioural model
module tb_trigger_conditioner;
  localparam int FW = 4;
  localparam int CW = 8;
  localparam int HW = 16;
  localparam int M_IDLE = 0, M_HOLD = 1, M_ARMED = 2, M_FIRED = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trigger_i = 1'b0;
  logic          arm_i = 1'b0;
  logic          disarm_i = 1'b0;
  logic [1:0]    edge_sel_i = 2'b00;
  logic [FW-1:0] filter_len_i = '0;
  logic [CW-1:0] edge_count_i = '0;
  logic [HW-1:0] holdoff_i = '0;
  logic          trigger_o;
  logic          armed_o;
  logic          fired_o;
  logic [CW-1:0] edges_seen_o;

  int n_assert = 0;
  int n_fail = 0;

  // reference model state
  bit sync_q[$] = '{1'b0, 1'b0};
  bit m_filt = 0, m_filt_d = 0;
  int m_run = 0;
  int m_mode = M_IDLE;
  int m_hold_left = 0;
  int m_edges = 0;
  int m_sel = 0;
  int m_n = 1;
  bit m_trig = 0;

  trigger_conditioner #(.FILTER_W(FW), .COUNT_W(CW), .HOLDOFF_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .trigger_i(trigger_i), .arm_i(arm_i), .disarm_i(disarm_i),
    .edge_sel_i(edge_sel_i), .filter_len_i(filter_len_i), .edge_count_i(edge_count_i),
    .holdoff_i(holdoff_i), .trigger_o(trigger_o), .armed_o(armed_o), .fired_o(fired_o),
    .edges_seen_o(edges_seen_o)
  );

  always #10 clk = ~clk;

  task automatic model_step(input bit rst, input bit pin, input bit arm, input bit disarm,
                            input int sel, input int flen, input int cnt, input int hold);
    bit rise, fall, qual, old_filt;
    if (!rst) begin
      sync_q = '{1'b0, 1'b0};
      m_filt = 0; m_filt_d = 0; m_run = 0;
      m_mode = M_IDLE; m_hold_left = 0; m_edges = 0; m_sel = 0; m_n = 1; m_trig = 0;
      return;
    end
    rise = m_filt && !m_filt_d;
    fall = !m_filt && m_filt_d;
    qual = (m_sel == 0) ? rise : (m_sel == 1) ? fall : (m_sel == 2) ? (rise || fall) : 1'b0;
    m_trig = 0;
    if (disarm) begin
      m_mode = M_IDLE;
      m_edges = 0;
    end else if (arm) begin
      m_mode = M_HOLD;
      m_hold_left = hold + 1;
      m_edges = 0;
      m_sel = sel;
      m_n = (cnt == 0) ? 1 : cnt;
    end else if (m_mode == M_HOLD) begin
      m_hold_left--;
      if (m_hold_left == 0) m_mode = M_ARMED;
    end else if (m_mode == M_ARMED) begin
      if (m_sel == 3) begin
        if (m_filt) begin m_trig = 1; m_mode = M_FIRED; end
      end else if (qual) begin
        m_edges++;
        if (m_edges == m_n) begin m_trig = 1; m_mode = M_FIRED; end
      end
    end
    old_filt = m_filt;
    if (sync_q[0] != m_filt) begin
      m_run++;
      if (m_run == flen + 1) begin m_filt = sync_q[0]; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_filt_d = old_filt;
    sync_q.push_back(pin);
    void'(sync_q.pop_front());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(rst_n, trigger_i, arm_i, disarm_i, int'(edge_sel_i), int'(filter_len_i),
               int'(edge_count_i), int'(holdoff_i));
    @(negedge clk);
    chk("model_trigger_o", 32'(trigger_o), 32'(m_trig));
    chk("model_armed_o", 32'(armed_o), 32'((m_mode == M_HOLD) || (m_mode == M_ARMED)));
    chk("model_fired_o", 32'(fired_o), 32'(m_mode == M_FIRED));
    chk("model_edges_seen_o", 32'(edges_seen_o), 32'(m_edges));
  endtask

  task automatic pulse_arm();
    arm_i = 1'b1;
    cycle();
    arm_i = 1'b0;
  endtask

  task automatic wait_trig(input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (trigger_o) begin lat = i; break; end
    end
  endtask

  task automatic run_count(input int n, inout int ntrig);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (trigger_o) ntrig++;
    end
  endtask

  initial begin
    int lat;
    int ntrig;
    int trig_win;
    int run_left;

    // reset state
    repeat (3) cycle();
    chk("rst_trigger_o", 32'(trigger_o), 0);
    chk("rst_armed_o", 32'(armed_o), 0);
    chk("rst_fired_o", 32'(fired_o), 0);
    chk("rst_edges_seen_o", 32'(edges_seen_o), 0);

    // rising, F=0, N=1, holdoff=0: latency 3
    rst_n = 1'b1;
    edge_sel_i = 2'b00; filter_len_i = 0; edge_count_i = 1; holdoff_i = 0;
    pulse_arm();
    chk("armed_after_arm", 32'(armed_o), 1);
    repeat (5) cycle();
    trigger_i = 1'b1;
    wait_trig(10, lat);
    chk("latency_f0", 32'(lat), 3);
    chk("fired_at_trigger", 32'(fired_o), 1);
    chk("armed_low_at_trigger", 32'(armed_o), 0);
    cycle();
    chk("trigger_one_wide", 32'(trigger_o), 0);

    // F=3: 3-cycle pulse dropped, 4-cycle pulse fires at latency 6
    trigger_i = 1'b0;
    repeat (10) cycle();
    filter_len_i = 3;
    pulse_arm();
    repeat (3) cycle();
    ntrig = 0;
    trigger_i = 1'b1;
    run_count(3, ntrig);
    trigger_i = 1'b0;
    run_count(15, ntrig);
    chk("short_pulse_no_trigger", 32'(ntrig), 0);
    chk("short_pulse_no_edge", 32'(edges_seen_o), 0);
    lat = -1;
    trigger_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (trigger_o && lat < 0) lat = i;
      if (i == 3) trigger_i = 1'b0;
    end
    chk("latency_f3", 32'(lat), 6);
    filter_len_i = 0;
    repeat (5) cycle();

    // both edges, N=5
    edge_sel_i = 2'b10; edge_count_i = 5; holdoff_i = 0;
    pulse_arm();
    repeat (3) cycle();
    ntrig = 0; trig_win = -1;
    for (int k = 1; k <= 7; k++) begin
      trigger_i = ~trigger_i;
      for (int i = 0; i < 10; i++) begin
        cycle();
        if (trigger_o) begin ntrig++; trig_win = k; end
      end
      chk("both_edges_seen", 32'(edges_seen_o), 32'((k < 5) ? k : 5));
    end
    chk("both_trigger_count", 32'(ntrig), 1);
    chk("both_trigger_window", 32'(trig_win), 5);

    // holdoff=20: edge at ~10 ignored, edge at ~30 fires
    trigger_i = 1'b0;
    repeat (10) cycle();
    edge_sel_i = 2'b00; edge_count_i = 1; holdoff_i = 20;
    pulse_arm();
    repeat (9) cycle();
    ntrig = 0;
    trigger_i = 1'b1;
    run_count(5, ntrig);
    trigger_i = 1'b0;
    run_count(14, ntrig);
    chk("holdoff_no_trigger", 32'(ntrig), 0);
    chk("holdoff_edge_not_counted", 32'(edges_seen_o), 0);
    chk("holdoff_still_armed", 32'(armed_o), 1);
    trigger_i = 1'b1;
    wait_trig(10, lat);
    chk("post_holdoff_latency", 32'(lat), 3);
    chk("post_holdoff_edges", 32'(edges_seen_o), 1);

    // pin high through reset, holdoff=10 masks the spurious rising edge
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    edge_sel_i = 2'b00; edge_count_i = 1; holdoff_i = 10;
    pulse_arm();
    ntrig = 0;
    run_count(30, ntrig);
    chk("reset_high_no_trigger", 32'(ntrig), 0);
    chk("reset_high_armed", 32'(armed_o), 1);
    chk("reset_high_no_edge", 32'(edges_seen_o), 0);

    // level mode, pin already high
    edge_sel_i = 2'b11; holdoff_i = 0;
    pulse_arm();
    wait_trig(5, lat);
    chk("level_latency", 32'(lat), 1);
    chk("level_fired", 32'(fired_o), 1);

    // arm and disarm together: disarm wins
    arm_i = 1'b1; disarm_i = 1'b1;
    cycle();
    arm_i = 1'b0; disarm_i = 1'b0;
    chk("armdisarm_armed", 32'(armed_o), 0);
    chk("armdisarm_fired", 32'(fired_o), 0);
    repeat (5) cycle();
    chk("armdisarm_idle", 32'(armed_o), 0);

    // reset at 2 of 4 edges
    trigger_i = 1'b0;
    repeat (8) cycle();
    edge_sel_i = 2'b00; edge_count_i = 4; holdoff_i = 0;
    pulse_arm();
    repeat (3) cycle();
    ntrig = 0;
    for (int k = 0; k < 2; k++) begin
      trigger_i = 1'b1; run_count(5, ntrig);
      trigger_i = 1'b0; run_count(5, ntrig);
    end
    chk("midrst_edges_before", 32'(edges_seen_o), 2);
    rst_n = 1'b0;
    cycle();
    chk("midrst_trigger_o", 32'(trigger_o), 0);
    chk("midrst_armed_o", 32'(armed_o), 0);
    chk("midrst_fired_o", 32'(fired_o), 0);
    chk("midrst_edges", 32'(edges_seen_o), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      trigger_i = 1'b1; run_count(5, ntrig);
      trigger_i = 1'b0; run_count(5, ntrig);
    end
    chk("midrst_no_trigger", 32'(ntrig), 0);

    // random stimulus against the model
    run_left = 1;
    for (int c = 0; c < 2500; c++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        filter_len_i = FW'($urandom_range(0, 3));
      end
      run_left--;
      if (run_left == 0) begin
        trigger_i = ~trigger_i;
        run_left = $urandom_range(1, 8);
      end
      arm_i = ($urandom_range(0, 59) == 0);
      disarm_i = ($urandom_range(0, 249) == 0);
      edge_sel_i = 2'($urandom_range(0, 3));
      edge_count_i = CW'($urandom_range(0, 3));
      holdoff_i = HW'($urandom_range(0, 12));
      cycle();
    end
    arm_i = 1'b0; disarm_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
